// File: rtl/gpsdc_pkg.sv
// rtl/gpsdc_pkg.sv - shared types and field widths for the GPS distance calculator slice
//
// Contents:
//   state_t             feeder FSM states (PRIME, ARM, BUSY)
//   LON_W / LAT_W       point coordinate widths
//   D_W / A_W           calculator result widths
//   PT_W                packed FIFO entry width {lon, lat}
package gpsdc_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        ARM   = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam int LON_W = 24;
    localparam int LAT_W = 24;
    localparam int D_W   = 40;
    localparam int A_W   = 64;
    localparam int PT_W  = LON_W + LAT_W;

endpackage

// File: rtl/gps_pt_fifo.sv
// rtl/gps_pt_fifo.sv - synchronous point FIFO with full/empty/count flags
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, wdata       write request and entry; ignored while full
//   pop               read request; ignored while empty
//   rdata             head entry, valid whenever empty=0
//   full, empty       occupancy flags
//   count             number of stored entries
module gps_pt_fifo
    import gpsdc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/gps_point_feeder.sv
// rtl/gps_point_feeder.sv - buffers points and paces DEN strobes into the GPS distance calculator
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready/in_lon/in_lat   upstream point stream
//   DEN, LON_OUT, LAT_OUT         one-cycle point strobe and data to the calculator
//   Valid, a, D                   calculator result strobe and values
//   res_valid/res_ready/res_d/res_a/res_idx   downstream result slot
//   err                           sticky timeout / unexpected-Valid flag
module gps_point_feeder
    import gpsdc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LON_W-1:0] in_lon,
    input  logic [LAT_W-1:0] in_lat,
    output logic             DEN,
    output logic [LON_W-1:0] LON_OUT,
    output logic [LAT_W-1:0] LAT_OUT,
    input  logic             Valid,
    input  logic [A_W-1:0]   a,
    input  logic [D_W-1:0]   D,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [D_W-1:0]   res_d,
    output logic [A_W-1:0]   res_a,
    output logic [7:0]       res_idx,
    output logic             err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PT_W-1:0]   fifo_rdata;
    logic [FCW-1:0]    fifo_count_unused;
    logic              pop;
    logic              slot_free;
    logic              capture;
    logic              expire;
    logic              stray;
    logic              res_hs;
    logic [CNT_W-1:0]  to_cnt;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign res_hs    = res_valid && res_ready;

    gps_pt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({in_lon, in_lat}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:   if (pop) state_nxt = ARM;
            ARM:     if (pop) state_nxt = BUSY;
            BUSY:    if (capture || expire) state_nxt = ARM;
            default: state_nxt = PRIME;
        endcase
    end

    // A computing pop needs the result slot free by the time Valid returns,
    // so it waits for the slot to be empty or draining this cycle. The !DEN
    // term stops the first ARM pop from landing right after the priming DEN.
    always_comb begin
        pop       = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        slot_free = !res_valid || res_ready;
        case (state)
            PRIME: pop = !fifo_empty;
            ARM:   pop = !fifo_empty && slot_free && !DEN;
            BUSY: begin
                capture = Valid;
                expire  = !Valid && (to_cnt == TO_MAX);
            end
            default: ;
        endcase
        stray = Valid && (state != BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DEN       <= 1'b0;
            LON_OUT   <= '0;
            LAT_OUT   <= '0;
            to_cnt    <= '0;
            res_valid <= 1'b0;
            res_d     <= '0;
            res_a     <= '0;
            res_idx   <= '0;
            err       <= 1'b0;
        end else begin
            DEN <= pop;
            if (pop) begin
                {LON_OUT, LAT_OUT} <= fifo_rdata;
            end

            if (pop) begin
                to_cnt <= '0;
            end else if (state == BUSY && !expire) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            // Capture wins over a same-cycle drain so a result is never lost.
            if (capture) begin
                res_valid <= 1'b1;
                res_d     <= D;
                res_a     <= a;
            end else if (res_hs) begin
                res_valid <= 1'b0;
            end

            if (res_hs) begin
                res_idx <= res_idx + 8'd1;
            end

            if (expire || stray) begin
                err <= 1'b1;
            end
        end
    end

endmodule
